// File: rtl/clock_set_ctrl.sv
// Time-set controller for a seconds/minutes/hours clock. It captures the live
// time into shadow registers, edits one field at a time, then strobes a load.
module clock_set_ctrl #(
    parameter int SEC_MAX = 59,
    parameter int MIN_MAX = 59,
    parameter int HR_MAX  = 23
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mode_btn,
    input  logic       inc_btn,
    input  logic [6:0] cur_sec,
    input  logic [6:0] cur_min,
    input  logic [6:0] cur_hr,
    output logic       run_en,
    output logic [1:0] sel,
    output logic [6:0] load_sec,
    output logic [6:0] load_min,
    output logic [6:0] load_hr,
    output logic       loaden_sec,
    output logic       loaden_min,
    output logic       loaden_hr
);

    typedef enum logic [2:0] {RUN, SET_HR, SET_MIN, SET_SEC, COMMIT} state_t;

    state_t     state, state_nx;
    logic [6:0] sec_nx, min_nx, hr_nx;
    logic [1:0] sel_nx;

    // Values at or above the terminal (e.g. a bogus captured 70) wrap to 0.
    function automatic logic [6:0] wrap_inc(input logic [6:0] v, input logic [6:0] mx);
        return (v >= mx) ? 7'd0 : v + 7'd1;
    endfunction

    always_comb begin
        state_nx = state;
        sec_nx   = load_sec;
        min_nx   = load_min;
        hr_nx    = load_hr;
        case (state)
            RUN: if (mode_btn) begin
                state_nx = SET_HR;
                sec_nx   = cur_sec;
                min_nx   = cur_min;
                hr_nx    = cur_hr;
            end
            SET_HR: begin
                if (mode_btn)     state_nx = SET_MIN;
                else if (inc_btn) hr_nx    = wrap_inc(load_hr, 7'(HR_MAX));
            end
            SET_MIN: begin
                if (mode_btn)     state_nx = SET_SEC;
                else if (inc_btn) min_nx   = wrap_inc(load_min, 7'(MIN_MAX));
            end
            SET_SEC: begin
                if (mode_btn)     state_nx = COMMIT;
                else if (inc_btn) sec_nx   = wrap_inc(load_sec, 7'(SEC_MAX));
            end
            default: state_nx = RUN;
        endcase
    end

    always_comb begin
        sel_nx = 2'd0;
        case (state_nx)
            SET_HR:  sel_nx = 2'd1;
            SET_MIN: sel_nx = 2'd2;
            SET_SEC: sel_nx = 2'd3;
            default: sel_nx = 2'd0;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= RUN;
            run_en     <= 1'b1;
            sel        <= 2'd0;
            loaden_sec <= 1'b0;
            loaden_min <= 1'b0;
            loaden_hr  <= 1'b0;
            load_sec   <= 7'd0;
            load_min   <= 7'd0;
            load_hr    <= 7'd0;
        end else begin
            state      <= state_nx;
            run_en     <= (state_nx == RUN);
            sel        <= sel_nx;
            loaden_sec <= (state_nx == COMMIT);
            loaden_min <= (state_nx == COMMIT);
            loaden_hr  <= (state_nx == COMMIT);
            load_sec   <= sec_nx;
            load_min   <= min_nx;
            load_hr    <= hr_nx;
        end
    end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed plus random bench for clock_set_ctrl against a field-array reference model.
module tb_clock_set_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       mode_btn, inc_btn;
    logic [6:0] cur_sec, cur_min, cur_hr;
    logic       run_en;
    logic [1:0] sel;
    logic [6:0] load_sec, load_min, load_hr;
    logic       loaden_sec, loaden_min, loaden_hr;

    int n_assert = 0;
    int n_fail   = 0;

    // Model: mode 0 = running, 1..3 = editing field index (hr, min, sec), 4 = commit.
    int m_mode;
    int sh [4];
    int mx [4] = '{0, 23, 59, 59};

    clock_set_ctrl dut (
        .clk(clk), .reset(reset), .mode_btn(mode_btn), .inc_btn(inc_btn),
        .cur_sec(cur_sec), .cur_min(cur_min), .cur_hr(cur_hr),
        .run_en(run_en), .sel(sel),
        .load_sec(load_sec), .load_min(load_min), .load_hr(load_hr),
        .loaden_sec(loaden_sec), .loaden_min(loaden_min), .loaden_hr(loaden_hr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".run_en"},     32'(run_en),     32'(m_mode == 0));
        check({tag, ".sel"},        32'(sel),        (m_mode >= 1 && m_mode <= 3) ? 32'(m_mode) : 32'd0);
        check({tag, ".loaden_hr"},  32'(loaden_hr),  32'(m_mode == 4));
        check({tag, ".loaden_min"}, 32'(loaden_min), 32'(m_mode == 4));
        check({tag, ".loaden_sec"}, 32'(loaden_sec), 32'(m_mode == 4));
        check({tag, ".load_hr"},    32'(load_hr),    32'(sh[1]));
        check({tag, ".load_min"},   32'(load_min),   32'(sh[2]));
        check({tag, ".load_sec"},   32'(load_sec),   32'(sh[3]));
    endtask

    task automatic model_reset();
        m_mode = 0;
        for (int i = 0; i < 4; i++) sh[i] = 0;
    endtask

    task automatic model_step(input bit m, input bit i, input int s, input int mi, input int h);
        case (m_mode)
            0: if (m) begin
                sh[1] = h; sh[2] = mi; sh[3] = s;
                m_mode = 1;
            end
            1, 2, 3: begin
                if (m)      m_mode = m_mode + 1;
                else if (i) sh[m_mode] = (sh[m_mode] >= mx[m_mode]) ? 0 : sh[m_mode] + 1;
            end
            default: m_mode = 0;
        endcase
    endtask

    // Drive one cycle of inputs, step the model across the edge, compare after it.
    task automatic cyc(input string tag, input bit m, input bit i,
                       input int s = 0, input int mi = 0, input int h = 0);
        mode_btn = m; inc_btn = i;
        cur_sec = 7'(s); cur_min = 7'(mi); cur_hr = 7'(h);
        @(posedge clk);
        #1;
        model_step(m, i, s, mi, h);
        mode_btn = 1'b0; inc_btn = 1'b0;
        check_all(tag);
    endtask

    // Asynchronous reset pulse entirely between two clock edges.
    task automatic pulse_reset(input string tag);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        #1 reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; mode_btn = 1'b0; inc_btn = 1'b0;
        cur_sec = '0; cur_min = '0; cur_hr = '0;
        model_reset();
        #12;
        check_all("reset");
        @(posedge clk); #1 reset = 1'b0;
        cyc("run_idle", 0, 1, 1, 2, 3);

        // Capture 12:34:56
        cyc("capture", 1, 0, 56, 34, 12);
        check("capture.hr", 32'(load_hr), 32'd12);
        check("capture.sel", 32'(sel), 32'd1);

        // Hours up to 22, then wrap through 23 to 0
        for (int k = 0; k < 10; k++) cyc("hr_inc", 0, 1);
        check("hr22", 32'(load_hr), 32'd22);
        cyc("hr_wrap23", 0, 1);
        check("hr23", 32'(load_hr), 32'd23);
        cyc("hr_wrap0", 0, 1);
        check("hr0", 32'(load_hr), 32'd0);
        check("hr_wrap.min", 32'(load_min), 32'd34);

        // Build 05:59:00 and commit
        for (int k = 0; k < 5; k++) cyc("set_hr", 0, 1);
        cyc("to_min", 1, 0);
        for (int k = 0; k < 25; k++) cyc("set_min", 0, 1);
        cyc("to_sec", 1, 0);
        for (int k = 0; k < 4; k++) cyc("set_sec", 0, 1);
        cyc("commit", 1, 1);
        check("commit.loaden", 32'({loaden_hr, loaden_min, loaden_sec}), 32'b111);
        check("commit.time", 32'({load_hr, load_min, load_sec}), {11'd0, 7'd5, 7'd59, 7'd0});
        cyc("post_commit", 1, 1);
        check("post_commit.run", 32'({run_en, sel, loaden_sec}), 32'b1000);
        cyc("run_again", 0, 0);

        // Simultaneous mode+inc in SET_MIN: mode wins
        cyc("cap2", 1, 0, 7, 10, 3);
        cyc("to_min2", 1, 0);
        cyc("simul", 1, 1);
        check("simul.sel", 32'(sel), 32'd3);
        check("simul.min", 32'(load_min), 32'd10);

        // Mid-edit reset in SET_MIN
        cyc("cmt2", 1, 0);
        cyc("run2", 0, 0);
        cyc("cap3", 1, 0, 2, 10, 1);
        cyc("to_min3", 1, 0);
        pulse_reset("midreset");
        for (int k = 0; k < 4; k++) cyc("after_reset", 0, 0);

        // Out-of-range captured seconds wraps on increment
        cyc("cap70", 1, 0, 70, 1, 1);
        cyc("oor_min", 1, 0);
        cyc("oor_sec", 1, 0);
        check("oor.sec70", 32'(load_sec), 32'd70);
        cyc("oor_inc", 0, 1);
        check("oor.sec0", 32'(load_sec), 32'd0);

        // Random traffic
        for (int k = 0; k < 500; k++) begin
            if ($urandom_range(0, 59) == 0) pulse_reset("rnd_reset");
            else cyc("rnd", $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
                     int'($urandom_range(0, 127)), int'($urandom_range(0, 127)),
                     int'($urandom_range(0, 127)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/clock_set_ctrl.md
CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

Interface
REQ-001 Parameters SHALL be, one per line:
  - SEC_MAX, 59, terminal value of seconds field.
  - MIN_MAX, 59, terminal value of minutes field.
  - HR_MAX, 23, terminal value of hours field.
REQ-002 Ports SHALL be (name, direction, width, meaning), clock and reset first:
  - clk  in  1  single clock, all logic on posedge.
  - reset  in  1  asynchronous, active-high reset.
  - mode_btn  in  1  one-cycle pulse, debounced upstream; advances set mode.
  - inc_btn  in  1  one-cycle pulse, debounced upstream; increments selected field.
  - cur_sec  in  7  live seconds count from timekeeping counter.
  - cur_min  in  7  live minutes count.
  - cur_hr  in  7  live hours count.
  - run_en  out  1  enable to timekeeping counters; 1 = clock runs.
  - sel  out  2  field being edited: 0 none, 1 hours, 2 minutes, 3 seconds.
  - load_sec  out  7  shadow seconds value to load.
  - load_min  out  7  shadow minutes value to load.
  - load_hr  out  7  shadow hours value to load.
  - loaden_sec  out  1  one-cycle load strobe to seconds counter.
  - loaden_min  out  1  one-cycle load strobe to minutes counter.
  - loaden_hr  out  1  one-cycle load strobe to hours counter.

Function
REQ-003 FSM states SHALL be RUN, SET_HR, SET_MIN, SET_SEC, COMMIT; all outputs registered.
REQ-004 RUN: run_en=1, sel=0, loaden_*=0; inc_btn ignored.
REQ-005 RUN + mode_btn SHALL, in the same edge, capture cur_sec/min/hr into shadow registers, go to SET_HR, and drop run_en to 0 from the next cycle.
REQ-006 SET_HR/SET_MIN/SET_SEC: run_en=0, sel=1/2/3 respectively.
REQ-007 In a SET state, inc_btn SHALL increment only the selected shadow field by 1; new value visible on load_* the next cycle.
REQ-008 Increment wrap: if field value >= its MAX, next value SHALL be 0; otherwise value+1; arithmetic 7-bit unsigned.
REQ-009 In a SET state, mode_btn SHALL advance SET_HR->SET_MIN->SET_SEC->COMMIT.
REQ-010 mode_btn and inc_btn in the same cycle: mode wins, increment discarded.
REQ-011 COMMIT SHALL last exactly one cycle, with loaden_sec, loaden_min and loaden_hr all 1 and load_* equal to the shadow values; run_en=0, sel=0.
REQ-012 COMMIT SHALL unconditionally go to RUN next cycle; buttons in COMMIT ignored.
REQ-013 Latency SHALL be: mode_btn in SET_SEC at edge N -> loaden_* high during cycle N+1 -> run_en high from cycle N+2.
REQ-014 load_* SHALL always reflect the shadow registers; they are held unchanged in RUN.
REQ-015 loaden_* SHALL never be asserted outside COMMIT.

Reset
REQ-016 reset=1 SHALL asynchronously force: state RUN, run_en=1, sel=0, loaden_*=0, shadow registers and load_* = 0.
REQ-017 reset asserted in any SET state or COMMIT SHALL abort the edit with no load strobe issued after reset deasserts.
REQ-018 Operation SHALL resume on the first posedge clk after reset deasserts.

Verification
REQ-019 Capture: cur=12:34:56, mode pulse -> next cycle sel=1, run_en=0, load_hr=12, load_min=34, load_sec=56.
REQ-020 Hour wrap: in SET_HR with shadow hr=22, two inc pulses -> load_hr 23 then 0; load_min/load_sec unchanged.
REQ-021 Full commit: set 05:59:00, three mode pulses from SET_HR -> exactly one cycle loaden_*=1 with load=05:59:00, then run_en=1, sel=0.
REQ-022 Simultaneous: SET_MIN, load_min=10, mode+inc same cycle -> sel=3, load_min stays 10.
REQ-023 Mid-edit reset: reset pulse in SET_MIN -> immediately run_en=1, sel=0, load_*=0, no loaden_* pulse afterwards.
REQ-024 Out-of-range capture: cur_sec=70 captured, inc in SET_SEC -> load_sec=0.
